// File: rtl/next_pc_unit_pkg.sv
// Shared branch resolution constants and the 2-bit saturating counter step.
package branch_pkg;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] ZER  = 3'd1;
    localparam logic [2:0] NZR  = 3'd2;
    localparam logic [2:0] DAT  = 3'd3;
    localparam logic [2:0] NDT  = 3'd4;
    localparam logic [2:0] JMP  = 3'd5;
    localparam logic [2:0] JLR  = 3'd6;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
        else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/next_pc_unit_if.sv
// Fetch/resolution bus of the next-PC unit; slave = next_pc_unit, master = its driver.
interface next_pc_unit_if #(parameter int XLEN = 32);

    logic            stall;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic            res_valid;
    logic [2:0]      res_opcode;
    logic [XLEN-1:0] res_pc;
    logic [XLEN-1:0] res_followed;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] d;
    logic [XLEN-1:0] rs1;
    logic            z;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;

    modport slave (
        input  stall, res_valid, res_opcode, res_pc, res_followed, imm, d, rs1, z,
        output pc, pred_taken, flush, redirect_pc
    );

    modport master (
        output stall, res_valid, res_opcode, res_pc, res_followed, imm, d, rs1, z,
        input  pc, pred_taken, flush, redirect_pc
    );

endinterface

// File: rtl/next_pc_unit_branch_predictor.sv
// Direct-mapped predictor: 2-bit counters, targets and valid bits.
// Combinational read for fetch, synchronous update from resolution.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [$clog2(ENTRIES)-1:0] i_rd_idx,
    output logic                       o_taken,
    output logic [XLEN-1:0]            o_target,
    input  logic                       i_wr_en,
    input  logic [$clog2(ENTRIES)-1:0] i_wr_idx,
    input  logic                       i_wr_taken,
    input  logic [XLEN-1:0]            i_wr_target
);

    logic [1:0]         r_ctr [ENTRIES];
    logic [XLEN-1:0]    r_tgt [ENTRIES];
    logic [ENTRIES-1:0] r_vld;

    // Read returns the pre-update entry when read and write hit the same index.
    assign o_taken  = r_vld[i_rd_idx] && r_ctr[i_rd_idx][1];
    assign o_target = r_tgt[i_rd_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_WNT;
                r_tgt[i] <= '0;
            end
            r_vld <= '0;
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_wr_taken);
            if (i_wr_taken) begin
                r_tgt[i_wr_idx] <= i_wr_target;
                r_vld[i_wr_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register with branch resolution and one-cycle mispredict redirect.
// Predictor tables are built only when BRANCH_PREDICT_EN is defined.
module next_pc_unit
    import branch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BHT_ENTRIES  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    next_pc_unit_if.slave  bus
);

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] JLR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] r_pc;
    logic            r_flush;
    logic [XLEN-1:0] r_redirect;

    logic            w_taken;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_jlr_target;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_actual;
    logic            w_mispredict;
    logic            w_pred;
    logic [XLEN-1:0] w_fetch_next;

    assign w_br_target  = bus.res_pc + bus.imm;
    assign w_jlr_target = (bus.rs1 + bus.imm) & JLR_MASK;
    assign w_seq        = bus.res_pc + PC_STEP;

    always_comb begin
        w_taken = 1'b0;
        case (bus.res_opcode)
            ZER:      w_taken = bus.z;
            NZR:      w_taken = !bus.z;
            DAT:      w_taken = |bus.d;
            NDT:      w_taken = ~|bus.d;
            JMP, JLR: w_taken = 1'b1;
            default:  w_taken = 1'b0;
        endcase
    end

    assign w_target     = (bus.res_opcode == JLR) ? w_jlr_target : w_br_target;
    assign w_actual     = w_taken ? w_target : w_seq;
    // NONE is checked too so an aliased taken prediction on a non-branch is caught.
    assign w_mispredict = bus.res_valid && (w_actual != bus.res_followed);

`ifdef BRANCH_PREDICT_EN
    localparam int IDXW = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0] w_pred_target;
    logic            w_update;

    assign w_update = bus.res_valid && (bus.res_opcode inside {[ZER:JLR]});

    branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (BHT_ENTRIES)
    ) u_bp (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rd_idx    (r_pc[IDXW+1:2]),
        .o_taken     (w_pred),
        .o_target    (w_pred_target),
        .i_wr_en     (w_update),
        .i_wr_idx    (bus.res_pc[IDXW+1:2]),
        .i_wr_taken  (w_taken),
        .i_wr_target (w_target)
    );

    assign w_fetch_next = w_pred ? w_pred_target : r_pc + PC_STEP;
`else
    assign w_pred       = 1'b0;
    assign w_fetch_next = r_pc + PC_STEP;
`endif

    // Redirect wins over STALL: the stalled fetch is on the wrong path anyway.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc       <= RESET_VECTOR;
            r_flush    <= 1'b0;
            r_redirect <= '0;
        end else begin
            r_flush <= w_mispredict;
            if (w_mispredict) begin
                r_pc       <= w_actual;
                r_redirect <= w_actual;
            end else if (!bus.stall) begin
                r_pc <= w_fetch_next;
            end
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pred_taken  = w_pred;
    assign bus.flush       = r_flush;
    assign bus.redirect_pc = r_redirect;

endmodule
